// File: rtl/seg7_hex_scan.sv
// Four-digit common-anode hex display scanner with per-frame snapshot,
// optional leading-zero blanking and per-digit decimal points.
module seg7_hex_scan #(
    parameter int DIV      = 100000,
    parameter int DIV_W    = 17,
    parameter bit BLANK_LZ = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] value,
    input  logic [3:0]  dp,
    input  logic        enable,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp_n,
    output logic        frame
);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

    logic [DIV_W-1:0] div_cnt;
    logic [1:0]       idx;
    logic [15:0]      shadow_val;
    logic [3:0]       shadow_dp;

    logic        tick;
    logic        load;
    logic [15:0] upper;
    logic [3:0]  nib;
    logic        blank;
    logic [3:0]  an_sel;

    function automatic logic [6:0] decode(input logic [3:0] n);
        case (n)
            4'h0:    decode = 7'h40;
            4'h1:    decode = 7'h79;
            4'h2:    decode = 7'h24;
            4'h3:    decode = 7'h30;
            4'h4:    decode = 7'h19;
            4'h5:    decode = 7'h12;
            4'h6:    decode = 7'h02;
            4'h7:    decode = 7'h78;
            4'h8:    decode = 7'h00;
            4'h9:    decode = 7'h10;
            4'hA:    decode = 7'h08;
            4'hB:    decode = 7'h03;
            4'hC:    decode = 7'h46;
            4'hD:    decode = 7'h21;
            4'hE:    decode = 7'h06;
            default: decode = 7'h0E;
        endcase
    endfunction

    // upper holds nibbles idx..3 shifted down, so its low nibble is the digit
    // and a zero value means everything from this digit leftwards is zero.
    always_comb begin
        tick   = (div_cnt == DIV_LAST);
        load   = tick && (idx == 2'd3);
        upper  = shadow_val >> {idx, 2'b00};
        nib    = upper[3:0];
        blank  = BLANK_LZ && (idx != 2'd0) && (upper == 16'd0) && !shadow_dp[idx];
        an_sel = 4'hF;
        an_sel[idx] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt    <= '0;
            idx        <= 2'd0;
            shadow_val <= 16'h0000;
            shadow_dp  <= 4'h0;
            frame      <= 1'b0;
            an         <= 4'hF;
            seg        <= 7'h7F;
            dp_n       <= 1'b1;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
            if (tick)
                idx <= idx + 2'd1;
            if (load) begin
                shadow_val <= value;
                shadow_dp  <= dp;
            end
            frame <= load;
            if (!enable || blank) begin
                an   <= 4'hF;
                seg  <= 7'h7F;
                dp_n <= 1'b1;
            end else begin
                an   <= an_sel;
                seg  <= decode(nib);
                dp_n <= ~shadow_dp[idx];
            end
        end
    end

endmodule
